// File: rtl/data_memory_ctrl_if.sv
// Request/response bus between a load/store master and data_memory_ctrl.
interface data_memory_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_memory_ctrl.sv
// Byte-addressable RV32 data memory with a single-outstanding request FSM,
// optional wait states and fault reporting (illegal size, misaligned, OOB).
// Optional feature: define DMEM_MISALIGN_TRAP_EN to fault misaligned half/word
// accesses instead of silently aligning them.
module data_memory_ctrl #(
  parameter int unsigned DEPTH_BYTES = 4096,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] OOB_DATA    = 32'hDEAD_BEEF
) (
  input logic               clk,
  input logic               reset,
  data_memory_ctrl_if.slave bus
);

  localparam int unsigned AW        = $clog2(DEPTH_BYTES);
  localparam logic [3:0]  WAIT_LAST = 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [7:0]  mem_q [DEPTH_BYTES];

  logic          accept_c;
  logic          cur_we_c;
  logic [2:0]    cur_f3_c;
  logic [31:0]   cur_addr_c;
  logic [2:0]    size_c;
  logic [AW-1:0] align_mask_c;
  logic [AW-1:0] idx_c;
  logic          illegal_c;
  logic          misalign_c;
  logic          oob_c;
  logic          err_c;
  logic [31:0]   word_c;
  logic [31:0]   ld_c;

  assign accept_c = bus.req_valid && bus.req_ready;

  // Decode from the live request in IDLE (accept edge), else from the latched one.
  assign cur_we_c   = (state_q == S_IDLE) ? bus.req_we     : we_q;
  assign cur_f3_c   = (state_q == S_IDLE) ? bus.req_funct3 : funct3_q;
  assign cur_addr_c = (state_q == S_IDLE) ? bus.req_addr   : addr_q;

  // Access size and alignment mask from the size code.
  always_comb begin
    size_c       = 3'd4;
    align_mask_c = '0;
    case (cur_f3_c[1:0])
      2'b00: size_c = 3'd1;
      2'b01: begin size_c = 3'd2; align_mask_c = AW'(1); end
      default: begin size_c = 3'd4; align_mask_c = AW'(3); end
    endcase
  end

  assign illegal_c = (cur_f3_c == 3'b011) || (cur_f3_c == 3'b110) ||
                     (cur_f3_c == 3'b111) || (cur_f3_c[2] && cur_we_c);

`ifdef DMEM_MISALIGN_TRAP_EN
  assign misalign_c = ((cur_f3_c[1:0] == 2'b01) && cur_addr_c[0]) ||
                      ((cur_f3_c[1:0] == 2'b10) && (cur_addr_c[1:0] != 2'b00));
`else
  assign misalign_c = 1'b0;
`endif

  // Bounds are judged on the raw address in 33 bits so the top of the space cannot wrap.
  assign oob_c = (({1'b0, cur_addr_c} + 33'(size_c) - 33'd1) >= 33'(DEPTH_BYTES));
  assign err_c = illegal_c || misalign_c || oob_c;

  assign idx_c  = cur_addr_c[AW-1:0] & ~align_mask_c;
  assign word_c = {mem_q[idx_c + AW'(3)], mem_q[idx_c + AW'(2)],
                   mem_q[idx_c + AW'(1)], mem_q[idx_c]};

  // Load extension by size code.
  always_comb begin
    ld_c = '0;
    case (cur_f3_c)
      3'b000:  ld_c = {{24{word_c[7]}}, word_c[7:0]};
      3'b001:  ld_c = {{16{word_c[15]}}, word_c[15:0]};
      3'b010:  ld_c = word_c;
      3'b100:  ld_c = {24'd0, word_c[7:0]};
      3'b101:  ld_c = {16'd0, word_c[15:0]};
      default: ld_c = '0;
    endcase
  end

  // Next state, wait counter and response payload captured on entry to RESP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = '0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          cnt_d   = '0;
          state_d = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
        end
      end
      S_WAIT: begin
        if (cnt_q == WAIT_LAST) state_d = S_RESP;
        else                    cnt_d   = cnt_q + 4'd1;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_RESP && state_q != S_RESP) begin
      err_d = err_c;
      if (illegal_c || misalign_c || cur_we_c) rdata_d = '0;
      else if (oob_c)                          rdata_d = OOB_DATA;
      else                                     rdata_d = ld_c;
    end
  end

  // State, counter, response and request-latch registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      we_q     <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept_c) begin
        we_q     <= bus.req_we;
        funct3_q <= bus.req_funct3;
        addr_q   <= bus.req_addr;
      end
    end
  end

  // Byte-lane store commit on the accept edge; faulted stores write nothing.
  always_ff @(posedge clk) begin
    if (accept_c && cur_we_c && !err_c) begin
      for (int b = 0; b < 4; b++) begin
        if (3'(b) < size_c) mem_q[idx_c + AW'(b)] <= bus.req_wdata[8*b +: 8];
      end
    end
  end

  assign bus.req_ready = (state_q == S_IDLE) && !reset;
  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench: one zero-wait and one three-wait-state instance side by side.
module tb_data_memory_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  data_memory_ctrl_if b0();
  data_memory_ctrl_if b3();

  data_memory_ctrl #(.DEPTH_BYTES(4096), .WAIT_STATES(0), .OOB_DATA(32'hDEAD_BEEF))
    dut0 (.clk(clk), .reset(reset), .bus(b0.slave));
  data_memory_ctrl #(.DEPTH_BYTES(4096), .WAIT_STATES(3), .OOB_DATA(32'hDEAD_BEEF))
    dut3 (.clk(clk), .reset(reset), .bus(b3.slave));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit s3, input logic v, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    if (s3) begin
      b3.req_valid = v; b3.req_we = we; b3.req_funct3 = f3; b3.req_addr = a; b3.req_wdata = wd;
    end else begin
      b0.req_valid = v; b0.req_we = we; b0.req_funct3 = f3; b0.req_addr = a; b0.req_wdata = wd;
    end
  endtask

  function automatic logic rdy(input bit s3);
    return s3 ? b3.req_ready : b0.req_ready;
  endfunction
  function automatic logic vld(input bit s3);
    return s3 ? b3.rsp_valid : b0.rsp_valid;
  endfunction
  function automatic logic [31:0] rdat(input bit s3);
    return s3 ? b3.rsp_rdata : b0.rsp_rdata;
  endfunction
  function automatic logic erro(input bit s3);
    return s3 ? b3.rsp_err : b0.rsp_err;
  endfunction

  // One complete request/response; called just after a falling edge.
  task automatic xact(input bit s3, input string tag, input logic we, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
    int n;
    int lat;
    drive(s3, 1'b1, we, f3, a, wd);
    n = 0;
    while (!rdy(s3) && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) check({tag, " ready_timeout"}, 32'd0, 32'd1);
    @(negedge clk);
    drive(s3, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    lat = 1;
    while (!vld(s3) && lat < 20) begin @(negedge clk); lat++; end
    check({tag, " lat"},   32'(lat),        32'(exp_lat));
    check({tag, " rdata"}, rdat(s3),        exp_rd);
    check({tag, " err"},   32'(erro(s3)),   32'(exp_err));
    @(negedge clk);
    check({tag, " strobe"}, 32'(vld(s3)),   32'd0);
  endtask

  int seen;

  initial begin
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst ready0", 32'(b0.req_ready), 32'd0);
    check("rst ready3", 32'(b3.req_ready), 32'd0);
    check("rst valid",  32'(b0.rsp_valid), 32'd0);
    check("rst rdata",  b0.rsp_rdata,      32'd0);
    check("rst err",    32'(b0.rsp_err),   32'd0);
    reset = 1'b0;
    #1;
    check("post-rst ready0", 32'(b0.req_ready), 32'd1);
    check("post-rst ready3", 32'(b3.req_ready), 32'd1);
    @(negedge clk);

    // Basic word store/load and sub-word sign/zero extension.
    xact(0, "sw10",  1, 3'b010, 32'h10, 32'h8081_8283, 32'h0, 0, 1);
    xact(0, "lw10",  0, 3'b010, 32'h10, 32'h0, 32'h8081_8283, 0, 1);
    xact(0, "lb10",  0, 3'b000, 32'h10, 32'h0, 32'hFFFF_FF83, 0, 1);
    xact(0, "lbu13", 0, 3'b100, 32'h13, 32'h0, 32'h0000_0080, 0, 1);
    xact(0, "lh12",  0, 3'b001, 32'h12, 32'h0, 32'hFFFF_8081, 0, 1);
    xact(0, "lhu10", 0, 3'b101, 32'h10, 32'h0, 32'h0000_8283, 0, 1);

    // Partial stores touch only their lanes.
    xact(0, "sb11",   1, 3'b000, 32'h11, 32'hFFFF_FF5A, 32'h0, 0, 1);
    xact(0, "lw10b",  0, 3'b010, 32'h10, 32'h0, 32'h8081_5A83, 0, 1);
    xact(0, "sh12",   1, 3'b001, 32'h12, 32'h1234_BEEF, 32'h0, 0, 1);
    xact(0, "lw10h",  0, 3'b010, 32'h10, 32'h0, 32'hBEEF_5A83, 0, 1);

    // Top-of-memory boundary.
    xact(0, "sw4092", 1, 3'b010, 32'd4092, 32'h5566_7788, 32'h0, 0, 1);
`ifdef DMEM_MISALIGN_TRAP_EN
    xact(0, "lw4094", 0, 3'b010, 32'd4094, 32'h0, 32'h0, 1, 1);
    xact(0, "lh4095", 0, 3'b001, 32'd4095, 32'h0, 32'h0, 1, 1);
`else
    xact(0, "lw4094", 0, 3'b010, 32'd4094, 32'h0, 32'hDEAD_BEEF, 1, 1);
    xact(0, "lh4095", 0, 3'b001, 32'd4095, 32'h0, 32'hDEAD_BEEF, 1, 1);
`endif
    xact(0, "sw4094",  1, 3'b010, 32'd4094, 32'hAABB_CCDD, 32'h0, 1, 1);
    xact(0, "lw4092",  0, 3'b010, 32'd4092, 32'h0, 32'h5566_7788, 0, 1);
    xact(0, "lb4095",  0, 3'b000, 32'd4095, 32'h0, 32'h0000_0055, 0, 1);
    xact(0, "lbu4096", 0, 3'b100, 32'd4096, 32'h0, 32'hDEAD_BEEF, 1, 1);
    xact(0, "lbuFFFF", 0, 3'b100, 32'hFFFF_FFFF, 32'h0, 32'hDEAD_BEEF, 1, 1);
    xact(0, "sbOOB",   1, 3'b000, 32'd4096, 32'h0000_0011, 32'h0, 1, 1);

    // Misaligned word store.
    xact(0, "sw20", 1, 3'b010, 32'h20, 32'hCAFE_F00D, 32'h0, 0, 1);
`ifdef DMEM_MISALIGN_TRAP_EN
    xact(0, "sw21",  1, 3'b010, 32'h21, 32'h1122_3344, 32'h0, 1, 1);
    xact(0, "lw20",  0, 3'b010, 32'h20, 32'h0, 32'hCAFE_F00D, 0, 1);
`else
    xact(0, "sw21",  1, 3'b010, 32'h21, 32'h1122_3344, 32'h0, 0, 1);
    xact(0, "lw20",  0, 3'b010, 32'h20, 32'h0, 32'h1122_3344, 0, 1);
`endif

    // Illegal size codes.
    xact(0, "f3_011",  0, 3'b011, 32'h10, 32'h0, 32'h0, 1, 1);
    xact(0, "f3_111",  0, 3'b111, 32'h10, 32'h0, 32'h0, 1, 1);
    xact(0, "sbu_ill", 1, 3'b100, 32'h10, 32'h0000_00FF, 32'h0, 1, 1);
    xact(0, "lw10c",   0, 3'b010, 32'h10, 32'h0, 32'hBEEF_5A83, 0, 1);

    // Wait-state instance: latency and held-request acceptance window.
    xact(1, "sw40", 1, 3'b010, 32'h40, 32'h0102_0304, 32'h0, 0, 4);
    drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h40, 32'h0);
    check("w3 ready N", 32'(b3.req_ready), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check($sformatf("w3 ready N+%0d", k), 32'(b3.req_ready), 32'd0);
      check($sformatf("w3 valid N+%0d", k), 32'(b3.rsp_valid), 32'(k == 4));
      if (k == 4) check("w3 rdata", b3.rsp_rdata, 32'h0102_0304);
    end
    @(negedge clk);
    check("w3 ready N+5", 32'(b3.req_ready), 32'd1);
    check("w3 valid N+5", 32'(b3.rsp_valid), 32'd0);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    check("w3 ready N+6", 32'(b3.req_ready), 32'd0);
    repeat (2) @(negedge clk);
    check("w3 valid N+8", 32'(b3.rsp_valid), 32'd0);
    @(negedge clk);
    check("w3 valid N+9", 32'(b3.rsp_valid), 32'd1);
    check("w3 rdata2",    b3.rsp_rdata, 32'h0102_0304);
    @(negedge clk);
    check("w3 valid N+10", 32'(b3.rsp_valid), 32'd0);

    // Reset while a store waits: response dropped, store kept.
    drive(1'b1, 1'b1, 1'b1, 3'b010, 32'h44, 32'h0A0B_0C0D);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    check("rw ready wait", 32'(b3.req_ready), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    seen = int'(b3.rsp_valid);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rw ready after", 32'(b3.req_ready), 32'd1);
    seen += int'(b3.rsp_valid);
    repeat (6) begin @(negedge clk); seen += int'(b3.rsp_valid); end
    check("rw no rsp", 32'(seen), 32'd0);
    xact(1, "lw44",   0, 3'b010, 32'h44, 32'h0, 32'h0A0B_0C0D, 0, 4);
    xact(1, "f3_011w", 0, 3'b011, 32'h44, 32'h0, 32'h0, 1, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
